// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register widths and operand-fetch FSM state encoding
package riscv_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_ADDR  = 2'd1;
    localparam logic [STATE_W-1:0] S_DATA  = 2'd2;
    localparam logic [STATE_W-1:0] S_VALID = 2'd3;

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: request, writeback, register-file and operand signals of the fetch unit
interface operand_fetch_if #(
    parameter int DATA_W = riscv_pkg::DATA_W,
    parameter int ADDR_W = riscv_pkg::ADDR_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rf_read_reg_num1;
    logic [ADDR_W-1:0] rf_read_reg_num2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_regwrite;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    modport master (
        input  req_valid, req_rs1, req_rs2, wb_valid, wb_rd, wb_data,
               rf_read_data1, rf_read_data2, op_ready,
        output req_ready, rf_read_reg_num1, rf_read_reg_num2,
               rf_write_reg, rf_write_data, rf_regwrite, op_valid, op_a, op_b
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, wb_valid, wb_rd, wb_data,
               rf_read_data1, rf_read_data2, op_ready,
        input  req_ready, rf_read_reg_num1, rf_read_reg_num2,
               rf_write_reg, rf_write_data, rf_regwrite, op_valid, op_a, op_b
    );

endinterface

// File: rtl/operand_bypass.sv
// operand_bypass: per-operand writeback compare, bypass latch and operand select (forwarding enabled by OPERAND_FETCH_BYPASS_EN)
module operand_bypass #(
    parameter int DATA_W = riscv_pkg::DATA_W,
    parameter int ADDR_W = riscv_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              track,
    input  logic              capture,
    input  logic              live,
    input  logic [ADDR_W-1:0] rs,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] op
);

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic              hit;
    logic              byp_valid;
    logic [DATA_W-1:0] byp_data;

    // x0 never forwards, so its operand always comes from the register file
    assign hit = BYPASS_EN && wb_valid && wb_rd != '0 && wb_rd == rs;

    // remember the newest writeback to this operand while the read is in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            byp_valid <= 1'b0;
            byp_data  <= '0;
        end else if (clear) begin
            byp_valid <= 1'b0;
        end else if (track && hit) begin
            byp_valid <= 1'b1;
            byp_data  <= wb_data;
        end
    end

    // a writeback in the capture cycle is newer than both the latch and the register file
    always_ff @(posedge clock) begin
        if (reset)
            op <= '0;
        else if (capture)
            op <= hit ? wb_data : byp_valid ? byp_data : rf_data;
        else if (live && hit)
            op <= wb_data;
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: four-state operand fetch from a registered register file, with optional writeback forwarding (OPERAND_FETCH_BYPASS_EN)
module operand_fetch #(
    parameter int DATA_W = riscv_pkg::DATA_W,
    parameter int ADDR_W = riscv_pkg::ADDR_W
) (
    input logic            clock,
    input logic            reset,
    operand_fetch_if.master bus
);

    import riscv_pkg::*;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               accept;
    logic [ADDR_W-1:0]  rs1_q;
    logic [ADDR_W-1:0]  rs2_q;

    assign accept               = bus.req_valid && bus.req_ready;
    assign bus.req_ready        = state == S_IDLE && !reset;
    assign bus.op_valid         = state == S_VALID && !reset;
    assign bus.rf_read_reg_num1 = rs1_q;
    assign bus.rf_read_reg_num2 = rs2_q;
    assign bus.rf_write_reg     = bus.wb_rd;
    assign bus.rf_write_data    = bus.wb_data;
    assign bus.rf_regwrite      = bus.wb_valid && bus.wb_rd != '0;

    // IDLE -> ADDR -> DATA -> VALID, retiring only on op_ready
    always_comb begin
        state_nxt = state == S_IDLE ? (accept ? S_ADDR : S_IDLE)
                  : state == S_ADDR ? S_DATA
                  : state == S_DATA ? S_VALID
                  : (bus.op_ready ? S_IDLE : S_VALID);
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // read addresses are latched on acceptance and held until the next request
    always_ff @(posedge clock) begin
        if (reset) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            rs1_q <= bus.req_rs1;
            rs2_q <= bus.req_rs2;
        end
    end

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_a (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .track   (state == S_ADDR || state == S_DATA),
        .capture (state == S_DATA),
        .live    (state == S_VALID),
        .rs      (rs1_q),
        .wb_valid(bus.wb_valid),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .rf_data (bus.rf_read_data1),
        .op      (bus.op_a)
    );

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_b (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .track   (state == S_ADDR || state == S_DATA),
        .capture (state == S_DATA),
        .live    (state == S_VALID),
        .rs      (rs2_q),
        .wb_valid(bus.wb_valid),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .rf_data (bus.rf_read_data2),
        .op      (bus.op_b)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed operand-fetch scenarios against a registered register-file model, scoreboard-checked
module tb_operand_fetch;

    import riscv_pkg::*;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic rf_load;
    logic [DATA_W-1:0] regs [32];
    logic [2*DATA_W-1:0] sb [$];
    logic [2*DATA_W-1:0] mon_e;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // register file with one edge of read latency, read-before-write
    always @(posedge clock) begin
        if (rf_load)
            for (int i = 0; i < 32; i++) regs[i] <= DATA_W'(i);
        else if (bus.rf_regwrite)
            regs[bus.rf_write_reg] <= bus.rf_write_data;
        bus.rf_read_data1 <= regs[bus.rf_read_reg_num1];
        bus.rf_read_data2 <= regs[bus.rf_read_reg_num2];
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                          input bit push, input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
        bus.req_rs1   = r1;
        bus.req_rs2   = r2;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 8 && !bus.req_ready; i++) step();
        chk("req_ready_accept", DATA_W'(bus.req_ready), 1);
        step();
        bus.req_valid = 1'b0;
        if (push) sb.push_back({ea, eb});
    endtask

    // monitor: every operand handshake must match the oldest expected pair
    always @(negedge clock) begin
        if (!reset && bus.op_valid && bus.op_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_op: got op_a %h op_b %h expected no operand", bus.op_a, bus.op_b);
            end else begin
                mon_e = sb.pop_front();
                chk("op_a", bus.op_a, mon_e[2*DATA_W-1:DATA_W]);
                chk("op_b", bus.op_b, mon_e[DATA_W-1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        rf_load       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.op_ready  = 1'b1;
        step();
        chk("req_ready_in_reset", DATA_W'(bus.req_ready), 0);
        step();
        rf_load = 1'b0;
        reset   = 1'b0;
        #1;
        chk("rst_op_valid", DATA_W'(bus.op_valid), 0);
        chk("rst_op_a", bus.op_a, 0);
        chk("rst_op_b", bus.op_b, 0);
        chk("rst_num1", DATA_W'(bus.rf_read_reg_num1), 0);
        chk("rst_num2", DATA_W'(bus.rf_read_reg_num2), 0);
        chk("rst_req_ready", DATA_W'(bus.req_ready), 1);

        accept(5, 7, 1, 5, 7);
        chk("num1_latched", DATA_W'(bus.rf_read_reg_num1), 5);
        chk("num2_latched", DATA_W'(bus.rf_read_reg_num2), 7);
        chk("op_valid_addr", DATA_W'(bus.op_valid), 0);
        step();
        chk("op_valid_data", DATA_W'(bus.op_valid), 0);
        step();
        chk("op_valid_latency", DATA_W'(bus.op_valid), 1);
        chk("req_ready_valid", DATA_W'(bus.req_ready), 0);
        step();
        chk("op_valid_retired", DATA_W'(bus.op_valid), 0);

        accept(5, 2, 1, BYP ? 32'hDEAD : 32'd5, 2);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5;
        bus.wb_data  = 32'hDEAD;
        #1;
        chk("regwrite_rd5", DATA_W'(bus.rf_regwrite), 1);
        step();
        bus.wb_valid = 1'b0;
        step();
        step();

        accept(9, 9, 1, BYP ? 32'h22 : 32'd9, BYP ? 32'h22 : 32'd9);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 9;
        bus.wb_data  = 32'h11;
        step();
        bus.wb_data  = 32'h22;
        step();
        bus.wb_valid = 1'b0;
        step();

        accept(0, 3, 1, 0, 3);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 0;
        bus.wb_data  = 32'hFFFF;
        #1;
        chk("regwrite_x0", DATA_W'(bus.rf_regwrite), 0);
        step();
        bus.wb_valid = 1'b0;
        step();
        step();

        bus.op_ready = 1'b0;
        accept(1, 7, 1, 1, BYP ? 32'h33 : 32'd7);
        step();
        step();
        chk("bp_op_valid", DATA_W'(bus.op_valid), 1);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 7;
        bus.wb_data  = 32'h33;
        step();
        bus.wb_valid = 1'b0;
        chk("bp_op_b_update", bus.op_b, BYP ? 32'h33 : 32'd7);
        step();
        step();
        chk("bp_req_ready", DATA_W'(bus.req_ready), 0);
        chk("bp_op_valid_held", DATA_W'(bus.op_valid), 1);
        chk("bp_op_a_stable", bus.op_a, 1);
        step();
        bus.op_ready = 1'b1;
        step();
        chk("bp_retired", DATA_W'(bus.op_valid), 0);

        accept(2, 3, 0, 0, 0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_op_valid", DATA_W'(bus.op_valid), 0);
        chk("abort_idle_ready", DATA_W'(bus.req_ready), 1);
        chk("abort_op_a", bus.op_a, 0);
        chk("abort_num1", DATA_W'(bus.rf_read_reg_num1), 0);
        step();
        step();
        step();

        accept(5, 7, 1, 32'hDEAD, 32'h33);
        step();
        step();
        step();
        step();
        chk("sb_empty", DATA_W'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
